// File: rtl/fft_stage_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT around one pipelined butterfly.
// Optional cycle counter output enabled by defining FFT_SEQ_CYCLE_COUNT_EN.
module fft_stage_sequencer #(
  parameter int LOG2N   = 4,
  parameter int MEM_LAT = 1,
  parameter int BFU_LAT = 5
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       rd_en,
  output logic [LOG2N-1:0]           rd_addr_a,
  output logic [LOG2N-1:0]           rd_addr_b,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       wr_en,
  output logic [LOG2N-1:0]           wr_addr_a,
  output logic [LOG2N-1:0]           wr_addr_b
`ifdef FFT_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]                cycle_count
`endif
);

  localparam int unsigned L  = MEM_LAT + BFU_LAT;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [SW-1:0] S_LAST     = SW'(LOG2N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(L - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [CW-1:0] drain_cnt;

  function automatic logic [LOG2N-1:0] pos_mask(input logic [SW-1:0] s);
    return (LOG2N'(1) << s) - LOG2N'(1);
  endfunction

  // Inserting a zero at bit s of k gives the a index; setting that bit gives b.
  function automatic logic [LOG2N-1:0] addr_a_of(input logic [KW-1:0] kk, input logic [SW-1:0] s);
    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] m;
    kx = {1'b0, kk};
    m  = pos_mask(s);
    return ((kx & ~m) << 1) | (kx & m);
  endfunction

  function automatic logic [LOG2N-1:0] addr_b_of(input logic [KW-1:0] kk, input logic [SW-1:0] s);
    return addr_a_of(kk, s) | (LOG2N'(1) << s);
  endfunction

  function automatic logic [KW-1:0] tw_of(input logic [KW-1:0] kk, input logic [SW-1:0] s);
    logic [LOG2N-1:0] pos;
    int unsigned      sh;
    pos = {1'b0, kk} & pos_mask(s);
    sh  = (LOG2N - 1) - int'(s);
    return KW'(pos << sh);
  endfunction

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      stage     <= '0;
      k         <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_ISSUE;
            busy      <= 1'b1;
            stage     <= '0;
            k         <= '0;
            rd_en     <= 1'b1;
            rd_addr_a <= addr_a_of('0, '0);
            rd_addr_b <= addr_b_of('0, '0);
            tw_addr   <= tw_of('0, '0);
          end
        end
        S_ISSUE: begin
          if (k == '1) begin
            rd_en     <= 1'b0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            k         <= k + 1'b1;
            rd_addr_a <= addr_a_of(k + 1'b1, stage);
            rd_addr_b <= addr_b_of(k + 1'b1, stage);
            tw_addr   <= tw_of(k + 1'b1, stage);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            if (stage == S_LAST) begin
              state <= S_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              stage     <= stage + 1'b1;
              k         <= '0;
              rd_en     <= 1'b1;
              rd_addr_a <= addr_a_of('0, stage + 1'b1);
              rd_addr_b <= addr_b_of('0, stage + 1'b1);
              tw_addr   <= tw_of('0, stage + 1'b1);
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_FINISH: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write side is the read side delayed by memory plus butterfly latency.
  logic [L-1:0]     pv;
  logic [LOG2N-1:0] pa [L];
  logic [LOG2N-1:0] pb [L];

  always_ff @(posedge clk) begin
    if (clear) begin
      pv <= '0;
      for (int unsigned i = 0; i < L; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      pv[0] <= rd_en;
      pa[0] <= rd_addr_a;
      pb[0] <= rd_addr_b;
      for (int unsigned i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end

  assign wr_en     = pv[L-1];
  assign wr_addr_a = pa[L-1];
  assign wr_addr_b = pb[L-1];

`ifdef FFT_SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      cycle_count <= '0;
    end else if (state == S_IDLE && start) begin
      cycle_count <= '0;
    end else if (busy && cycle_count != '1) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed self-checking bench for fft_stage_sequencer at N=16, MEM_LAT=1, BFU_LAT=5.
module tb_fft_stage_sequencer;

  localparam int LOG2N = 4;
  localparam int N     = 16;
  localparam int HALF  = 8;
  localparam int L     = 6;
  localparam int PER   = HALF + L;
  localparam int TOTAL = 57;
  localparam int NCAP  = 62;

  logic       clk = 1'b0;
  logic       clear, start;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] stage;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_addr;
`ifdef FFT_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  fft_stage_sequencer #(.LOG2N(LOG2N), .MEM_LAT(1), .BFU_LAT(5)) dut (
    .clk(clk), .clear(clear), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, c, got, exp);
    end
  endtask

  int ref_a [4][HALF];
  int ref_b [4][HALF];
  int ref_tw[4][HALF];

  logic       cap_rd [NCAP+1], cap_wr [NCAP+1], cap_busy [NCAP+1], cap_done [NCAP+1];
  logic [1:0] cap_st [NCAP+1];
  logic [3:0] cap_ra [NCAP+1], cap_rb [NCAP+1], cap_wa [NCAP+1], cap_wb [NCAP+1];
  logic [2:0] cap_tw [NCAP+1];
`ifdef FFT_SEQ_CYCLE_COUNT_EN
  logic [31:0] cap_cc [NCAP+1];
`endif

  task automatic capture(input int c);
    cap_rd[c] = rd_en;   cap_wr[c] = wr_en;   cap_busy[c] = busy; cap_done[c] = done;
    cap_st[c] = stage;   cap_ra[c] = rd_addr_a; cap_rb[c] = rd_addr_b; cap_tw[c] = tw_addr;
    cap_wa[c] = wr_addr_a; cap_wb[c] = wr_addr_b;
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    cap_cc[c] = cycle_count;
`endif
  endtask

  // Pulse start, then sample cycles 1..NCAP (cycle 1 = first cycle after start is taken).
  task automatic run_seq(input bit poke);
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= NCAP; c++) begin
      @(negedge clk);
      capture(c);
      start = (poke && (c == 20 || c == TOTAL)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int wr_cnt[4];
    int first_rd[4];
    int last_wr[4];
    int done_cnt;
    int total_wr;
    done_cnt = 0;
    total_wr = 0;
    for (int s = 0; s < 4; s++) begin
      wr_cnt[s] = 0; first_rd[s] = 1000; last_wr[s] = -1;
    end
    for (int c = 1; c <= NCAP; c++) begin
      int  s, j;
      bit  e_rd, e_wr, e_busy, e_done;
      if (c < TOTAL) begin
        s = (c - 1) / PER; j = (c - 1) % PER;
        e_rd = (j < HALF); e_wr = (j >= L); e_busy = 1'b1; e_done = 1'b0;
      end else begin
        s = 3; j = 0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_done = (c == TOTAL);
      end
      chk({tag, " rd_en"}, c, 32'(cap_rd[c]), 32'(e_rd));
      chk({tag, " wr_en"}, c, 32'(cap_wr[c]), 32'(e_wr));
      chk({tag, " busy"},  c, 32'(cap_busy[c]), 32'(e_busy));
      chk({tag, " done"},  c, 32'(cap_done[c]), 32'(e_done));
      chk({tag, " stage"}, c, 32'(cap_st[c]), 32'(s));
      if (e_rd) begin
        chk({tag, " rd_addr_a"}, c, 32'(cap_ra[c]), 32'(ref_a[s][j]));
        chk({tag, " rd_addr_b"}, c, 32'(cap_rb[c]), 32'(ref_b[s][j]));
        chk({tag, " tw_addr"},   c, 32'(cap_tw[c]), 32'(ref_tw[s][j]));
      end
      if (e_wr) begin
        chk({tag, " wr_addr_a"}, c, 32'(cap_wa[c]), 32'(ref_a[s][j-L]));
        chk({tag, " wr_addr_b"}, c, 32'(cap_wb[c]), 32'(ref_b[s][j-L]));
      end
      if (cap_wr[c] === 1'b1) begin
        wr_cnt[cap_st[c]]++; total_wr++; last_wr[cap_st[c]] = c;
      end
      if (cap_rd[c] === 1'b1 && first_rd[cap_st[c]] == 1000) first_rd[cap_st[c]] = c;
      if (cap_done[c] === 1'b1) done_cnt++;
      chk({tag, " busy_done_excl"}, c, 32'(cap_busy[c] & cap_done[c]), 32'd0);
    end
    for (int s = 0; s < 4; s++) chk({tag, " wr_per_stage"}, s, 32'(wr_cnt[s]), 32'd8);
    for (int s = 0; s < 3; s++) chk({tag, " raw_hazard"}, s, 32'(first_rd[s+1] > last_wr[s]), 32'd1);
    chk({tag, " wr_total"}, 0, 32'(total_wr), 32'd32);
    chk({tag, " done_count"}, 0, 32'(done_cnt), 32'd1);
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    chk({tag, " cycle_count_at_done"}, TOTAL, cap_cc[TOTAL], 32'd56);
    chk({tag, " cycle_count_hold"}, NCAP, cap_cc[NCAP], 32'd56);
`endif
  endtask

  typedef struct {
    int c;
    bit rd; int a; int b; int tw;
    bit wr; int wa; int wb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{c: 1,  rd: 1, a: 0,  b: 1,  tw: 0, wr: 0, wa: 0,  wb: 0};
    vecs[1] = '{c: 2,  rd: 1, a: 2,  b: 3,  tw: 0, wr: 0, wa: 0,  wb: 0};
    vecs[2] = '{c: 7,  rd: 1, a: 12, b: 13, tw: 0, wr: 1, wa: 0,  wb: 1};
    vecs[3] = '{c: 8,  rd: 1, a: 14, b: 15, tw: 0, wr: 1, wa: 2,  wb: 3};
    vecs[4] = '{c: 14, rd: 0, a: 0,  b: 0,  tw: 0, wr: 1, wa: 14, wb: 15};
    vecs[5] = '{c: 15, rd: 1, a: 0,  b: 2,  tw: 0, wr: 0, wa: 0,  wb: 0};
    vecs[6] = '{c: 16, rd: 1, a: 1,  b: 3,  tw: 4, wr: 0, wa: 0,  wb: 0};
    vecs[7] = '{c: 34, rd: 1, a: 9,  b: 13, tw: 2, wr: 0, wa: 0,  wb: 0};
    vecs[8] = '{c: 50, rd: 1, a: 7,  b: 15, tw: 7, wr: 1, wa: 1,  wb: 9};
    vecs[9] = '{c: 56, rd: 0, a: 0,  b: 0,  tw: 0, wr: 1, wa: 7,  wb: 15};

    // Reference addresses enumerated group by group, position by position.
    for (int s = 0; s < 4; s++) begin
      int span, k;
      span = 1 << s;
      k = 0;
      for (int grp = 0; grp < HALF / span; grp++)
        for (int pos = 0; pos < span; pos++) begin
          ref_a[s][k]  = grp * 2 * span + pos;
          ref_b[s][k]  = grp * 2 * span + pos + span;
          ref_tw[s][k] = pos * (HALF / span);
          k++;
        end
    end

    clear = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 0, 32'(busy), 32'd0);
    chk("reset done", 0, 32'(done), 32'd0);
    chk("reset rd_en", 0, 32'(rd_en), 32'd0);
    chk("reset wr_en", 0, 32'(wr_en), 32'd0);
    chk("reset stage", 0, 32'(stage), 32'd0);
    chk("reset addrs", 0, {rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, 13'd0, tw_addr}, 32'd0);
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    chk("reset cycle_count", 0, cycle_count, 32'd0);
`endif
    clear = 1'b0;

    // Run 1: start pulses while busy and in the done cycle must be ignored.
    run_seq(1'b1);
    check_run("run1");
    foreach (vecs[i]) begin
      chk("vec rd_en", vecs[i].c, 32'(cap_rd[vecs[i].c]), 32'(vecs[i].rd));
      chk("vec wr_en", vecs[i].c, 32'(cap_wr[vecs[i].c]), 32'(vecs[i].wr));
      if (vecs[i].rd) begin
        chk("vec rd_addr_a", vecs[i].c, 32'(cap_ra[vecs[i].c]), 32'(vecs[i].a));
        chk("vec rd_addr_b", vecs[i].c, 32'(cap_rb[vecs[i].c]), 32'(vecs[i].b));
        chk("vec tw_addr",   vecs[i].c, 32'(cap_tw[vecs[i].c]), 32'(vecs[i].tw));
      end
      if (vecs[i].wr) begin
        chk("vec wr_addr_a", vecs[i].c, 32'(cap_wa[vecs[i].c]), 32'(vecs[i].wa));
        chk("vec wr_addr_b", vecs[i].c, 32'(cap_wb[vecs[i].c]), 32'(vecs[i].wb));
      end
    end

    // Clear 20 cycles into a run, with a start pulse that must be dropped.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    chk("cycle_count restart", 1, cycle_count, 32'd0);
`endif
    repeat (19) @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    chk("clear busy", 21, 32'(busy), 32'd0);
    chk("clear rd_en", 21, 32'(rd_en), 32'd0);
    chk("clear wr_en", 21, 32'(wr_en), 32'd0);
    chk("clear stage", 21, 32'(stage), 32'd0);
    chk("clear rd_addr", 21, {24'd0, rd_addr_a, rd_addr_b}, 32'd0);
    for (int c = 22; c < 32; c++) begin
      @(negedge clk);
      chk("post-clear wr_en", c, 32'(wr_en), 32'd0);
      chk("post-clear busy", c, 32'(busy), 32'd0);
    end

    run_seq(1'b0);
    check_run("run2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
